// File: rtl/dcache_port_arbiter.sv
// Two-requester arbiter sharing one data cache port: round-robin on ties, optional lock
// ownership bounded by MAX_HOLD, registered load responses per requester.
module dcache_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester 0
  input  logic                  req_0,
  input  logic                  lock_0,
  input  logic                  we_0,
  input  logic [2:0]            funct3_0,
  input  logic [DATA_WIDTH-1:0] addr_0,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  output logic                  gnt_0,
  output logic                  rvalid_0,
  output logic [DATA_WIDTH-1:0] rdata_0,
  // requester 1
  input  logic                  req_1,
  input  logic                  lock_1,
  input  logic                  we_1,
  input  logic [2:0]            funct3_1,
  input  logic [DATA_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  output logic                  gnt_1,
  output logic                  rvalid_1,
  output logic [DATA_WIDTH-1:0] rdata_1,
  // cache side
  output logic                  WE,
  output logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] WD,
  input  logic [DATA_WIDTH-1:0] RD
);

  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
  localparam logic [CntW-1:0] HoldMax = CntW'(MAX_HOLD);

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnR0   = 2'd1,
    OwnR1   = 2'd2
  } owner_e;

  owner_e          owner_q, owner_d;
  logic            rr_q, rr_d;
  logic [CntW-1:0] hold_q, hold_d;

  logic            owner_act, owner_id, other_req;
  logic            win_vld, win_id, same_win;
  logic            ld_0, ld_1;
  logic            rvalid_0_q, rvalid_1_q;
  logic [DATA_WIDTH-1:0] rdata_0_q, rdata_1_q;

  // Winner selection: a live owner keeps the port unless it has saturated hold_cnt
  // while the other side is waiting.
  always_comb begin
    win_vld   = 1'b0;
    win_id    = 1'b0;
    owner_id  = (owner_q == OwnR1);
    owner_act = ((owner_q == OwnR0) && req_0) || ((owner_q == OwnR1) && req_1);
    other_req = owner_id ? req_0 : req_1;
    if (rst) begin
      win_vld = 1'b0;
    end else if (owner_act) begin
      win_vld = 1'b1;
      win_id  = ((hold_q == HoldMax) && other_req) ? ~owner_id : owner_id;
    end else if (req_0 && req_1) begin
      win_vld = 1'b1;
      win_id  = rr_q;
    end else if (req_0 || req_1) begin
      win_vld = 1'b1;
      win_id  = req_1;
    end
  end

  assign gnt_0 = win_vld & ~win_id;
  assign gnt_1 = win_vld &  win_id;
  assign ld_0  = gnt_0 & ~we_0;
  assign ld_1  = gnt_1 & ~we_1;

  always_comb begin
    WE     = 1'b0;
    funct3 = 3'b010;
    A      = '0;
    WD     = '0;
    if (win_vld) begin
      WE     = win_id ? we_1     : we_0;
      funct3 = win_id ? funct3_1 : funct3_0;
      A      = win_id ? addr_1   : addr_0;
      WD     = win_id ? wdata_1  : wdata_0;
    end
  end

  // Nonzero hold_q implies a grant last cycle, and that winner is the complement of rr_q.
  assign same_win = (hold_q != '0) && (win_id != rr_q);

  always_comb begin
    owner_d = OwnNone;
    rr_d    = rr_q;
    hold_d  = '0;
    if (win_vld) begin
      if (win_id) begin
        owner_d = lock_1 ? OwnR1 : OwnNone;
      end else begin
        owner_d = lock_0 ? OwnR0 : OwnNone;
      end
      rr_d = ~win_id;
      if (same_win) begin
        hold_d = (hold_q == HoldMax) ? hold_q : hold_q + CntW'(1);
      end else begin
        hold_d = CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OwnNone;
      rr_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_0_q <= 1'b0;
      rvalid_1_q <= 1'b0;
      rdata_0_q  <= '0;
      rdata_1_q  <= '0;
    end else begin
      rvalid_0_q <= ld_0;
      rvalid_1_q <= ld_1;
      if (ld_0) rdata_0_q <= RD;
      if (ld_1) rdata_1_q <= RD;
    end
  end

  assign rvalid_0 = rvalid_0_q;
  assign rvalid_1 = rvalid_1_q;
  assign rdata_0  = rdata_0_q;
  assign rdata_1  = rdata_1_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: byte-addressed cache model, table-driven grant vectors and a
// load-response scoreboard keyed by the cycle each rvalid is due.
module tb_dcache_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_0, lock_0, we_0, gnt_0, rvalid_0;
  logic        req_1, lock_1, we_1, gnt_1, rvalid_1;
  logic [2:0]  funct3_0, funct3_1, funct3;
  logic [31:0] addr_0, wdata_0, rdata_0, addr_1, wdata_1, rdata_1;
  logic        WE;
  logic [31:0] A, WD, RD;

  dcache_port_arbiter #(.DATA_WIDTH(32), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .lock_0(lock_0), .we_0(we_0), .funct3_0(funct3_0), .addr_0(addr_0),
    .wdata_0(wdata_0), .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
    .req_1(req_1), .lock_1(lock_1), .we_1(we_1), .funct3_1(funct3_1), .addr_1(addr_1),
    .wdata_1(wdata_1), .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
    .WE(WE), .funct3(funct3), .A(A), .WD(WD), .RD(RD)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- cache model ----------------
  logic [7:0] mem [int unsigned];
  int mem_ver = 0;

  function automatic logic [7:0] rb(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] w;
    w = {rb(a + 3), rb(a + 2), rb(a + 1), rb(a)};
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always @(A or funct3 or mem_ver) RD = load_val(A, funct3);

  always @(posedge clk) begin
    if (WE === 1'b1) begin
      mem[A] = WD[7:0];
      if (funct3[1:0] != 2'b00) mem[A + 1] = WD[15:8];
      if (funct3[1] == 1'b1) begin
        mem[A + 2] = WD[23:16];
        mem[A + 3] = WD[31:24];
      end
      mem_ver++;
    end
  end

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    mem[a]     = w[7:0];
    mem[a + 1] = w[15:8];
    mem[a + 2] = w[23:16];
    mem[a + 3] = w[31:24];
    mem_ver++;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic        e0, e1;
  logic [31:0] ed;

  always @(negedge clk) begin
    e0 = 1'b0;
    e1 = 1'b0;
    ed = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e0 = (sb[0].port == 0);
      e1 = (sb[0].port == 1);
      ed = sb[0].data;
      void'(sb.pop_front());
    end
    chk("rvalid_0", {31'b0, rvalid_0}, {31'b0, e0});
    chk("rvalid_1", {31'b0, rvalid_1}, {31'b0, e1});
    if (e0) chk("rdata_0", rdata_0, ed);
    if (e1) chk("rdata_1", rdata_1, ed);
  end

  // Called at posedge+1 with inputs already driven; checks grants and A mid-cycle.
  task automatic cyc_chk(input string name, input logic eg0, input logic eg1,
                         input logic [31:0] ea, input logic push, input logic [31:0] erd);
    exp_t e;
    @(negedge clk);
    chk({name, ".gnt_0"}, {31'b0, gnt_0}, {31'b0, eg0});
    chk({name, ".gnt_1"}, {31'b0, gnt_1}, {31'b0, eg1});
    chk({name, ".A"}, A, ea);
    if (push) begin
      e.port = eg1 ? 1 : 0;
      e.data = erd;
      e.due  = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r0, r1;
    logic        eg0, eg1;
    logic [31:0] ea, erd;
  } vec_t;
  vec_t tbl[6];

  logic [1:0] own_now;

  initial begin
    for (int k = 0; k < 6; k++) begin
      tbl[k].r0  = 1'b1;
      tbl[k].r1  = 1'b1;
      tbl[k].eg0 = (k % 2 == 0);
      tbl[k].eg1 = (k % 2 == 1);
      tbl[k].ea  = (k % 2 == 0) ? 32'h100 : 32'h200;
      tbl[k].erd = (k % 2 == 0) ? 32'h1111_2222 : 32'h3333_4444;
    end
    put_word(32'h100, 32'h1111_2222);
    put_word(32'h200, 32'h3333_4444);

    rst = 1'b1;
    req_0 = 1'b1; lock_0 = 1'b0; we_0 = 1'b0; funct3_0 = 3'b010; addr_0 = 32'h100; wdata_0 = '0;
    req_1 = 1'b1; lock_1 = 1'b0; we_1 = 1'b0; funct3_1 = 3'b010; addr_1 = 32'h200; wdata_1 = '0;

    // Held in reset with requests pending: port must stay idle.
    @(negedge clk);
    chk("rst.gnt", {30'b0, gnt_1, gnt_0}, 32'h0);
    chk("rst.WE", {31'b0, WE}, 32'h0);
    chk("rst.funct3", {29'b0, funct3}, 32'h2);
    chk("rst.A", A, 32'h0);
    chk("rst.WD", WD, 32'h0);
    chk("rst.rdata", rdata_0 | rdata_1, 32'h0);
    req_0 = 1'b0;
    req_1 = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Both requesters loading continuously alternate starting with requester 0.
    for (int k = 0; k < 6; k++) begin
      req_0 = tbl[k].r0;
      req_1 = tbl[k].r1;
      cyc_chk($sformatf("alt%0d", k), tbl[k].eg0, tbl[k].eg1, tbl[k].ea, 1'b1, tbl[k].erd);
    end

    req_0 = 1'b0;
    req_1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("idle%0d.WE", k), {31'b0, WE}, 32'h0);
      chk($sformatf("idle%0d.A", k), A, 32'h0);
      @(posedge clk);
      #1;
    end
    req_1 = 1'b1;
    #1 chk("idle.hold_cnt", 32'(dut.hold_q), 32'h0);
    cyc_chk("after_idle", 1'b0, 1'b1, 32'h200, 1'b1, 32'h3333_4444);
    req_1 = 1'b0;

    // SW then LW through requester 0.
    req_0 = 1'b1; we_0 = 1'b1; funct3_0 = 3'b010; addr_0 = 32'h1_0000; wdata_0 = 32'hDEAD_BEEF;
    #1;
    chk("sw.WE", {31'b0, WE}, 32'h1);
    chk("sw.WD", WD, 32'hDEAD_BEEF);
    cyc_chk("sw", 1'b1, 1'b0, 32'h1_0000, 1'b0, 32'h0);
    we_0 = 1'b0;
    cyc_chk("lw", 1'b1, 1'b0, 32'h1_0000, 1'b1, 32'hDEAD_BEEF);

    // SB then LBU of the same byte, then LW to confirm only one byte changed.
    we_0 = 1'b1; funct3_0 = 3'b000; addr_0 = 32'h1_0001; wdata_0 = 32'h1234_565A;
    cyc_chk("sb", 1'b1, 1'b0, 32'h1_0001, 1'b0, 32'h0);
    we_0 = 1'b0; funct3_0 = 3'b100;
    cyc_chk("lbu", 1'b1, 1'b0, 32'h1_0001, 1'b1, 32'h0000_005A);
    funct3_0 = 3'b010; addr_0 = 32'h1_0000;
    cyc_chk("lw2", 1'b1, 1'b0, 32'h1_0000, 1'b1, 32'hDEAD_5AEF);
    req_0 = 1'b0;
    cyc_chk("drain", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Reset pulse, then a locked requester 0 is preempted after MAX_HOLD grants.
    #2 rst = 1'b1;
    #4 rst = 1'b0;
    @(posedge clk);
    #1;
    addr_0 = 32'h100; lock_0 = 1'b1; req_0 = 1'b1; req_1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc_chk($sformatf("hold%0d", k), 1'b1, 1'b0, 32'h100, 1'b1, 32'h1111_2222);
    end
    cyc_chk("preempt", 1'b0, 1'b1, 32'h200, 1'b1, 32'h3333_4444);
    req_0 = 1'b0; req_1 = 1'b0; lock_0 = 1'b0;
    own_now = dut.owner_q;
    chk("preempt.owner", {30'b0, own_now}, 32'h0);
    cyc_chk("drain2", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Load granted, then reset arrives mid-way through the response cycle.
    req_0 = 1'b1;
    cyc_chk("ld_before_rst", 1'b1, 1'b0, 32'h100, 1'b0, 32'h0);
    req_0 = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst2.rvalid", {30'b0, rvalid_1, rvalid_0}, 32'h0);
    chk("rst2.gnt", {30'b0, gnt_1, gnt_0}, 32'h0);
    chk("rst2.WE", {31'b0, WE}, 32'h0);
    chk("rst2.funct3", {29'b0, funct3}, 32'h2);
    chk("rst2.A", A, 32'h0);
    chk("rst2.WD", WD, 32'h0);
    chk("rst2.rdata_0", rdata_0, 32'h0);
    chk("rst2.rdata_1", rdata_1, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    req_1 = 1'b1;
    cyc_chk("resume", 1'b0, 1'b1, 32'h200, 1'b1, 32'h3333_4444);
    req_1 = 1'b0;
    cyc_chk("end", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("scoreboard_empty", sb.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the address and data width.
REQ-002 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum consecutive grants to one requester while the other waits.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset; asynchronous and active-high.
REQ-005 The block SHALL have, for each requester i in {0,1}, port req_i, input, 1 bit, request valid.
REQ-006 The block SHALL have, for each i, port lock_i, input, 1 bit, which keeps ownership after the current grant.
REQ-007 The block SHALL have, for each i, port we_i, input, 1 bit, which selects a store (1) or a load (0).
REQ-008 The block SHALL have, for each i, port funct3_i, input, 3 bits, the access size code passed to the cache.
REQ-009 The block SHALL have, for each i, ports addr_i and wdata_i, inputs, DATA_WIDTH bits each, the byte address and the store data.
REQ-010 The block SHALL have, for each i, port gnt_i, output, 1 bit, which is asserted combinationally in the cycle the access is issued.
REQ-011 The block SHALL have, for each i, port rvalid_i, output, 1 bit, which pulses one cycle after a granted load.
REQ-012 The block SHALL have, for each i, port rdata_i, output, DATA_WIDTH bits, the registered load data.
REQ-013 The block SHALL have cache-side ports WE (output, 1), funct3 (output, 3), A (output, DATA_WIDTH) and WD (output, DATA_WIDTH), which drive the data cache port.
REQ-014 The block SHALL have cache-side port RD, input, DATA_WIDTH bits, the combinational read data from the cache.

Function
REQ-015 The block SHALL hold registered state consisting of owner {NONE, R0, R1}, rr_ptr (1 bit, the requester favoured on a tie) and hold_cnt (saturating counter up to MAX_HOLD).
REQ-016 The winner in a given cycle SHALL be the owner if that owner's req is high, unless hold_cnt==MAX_HOLD and the other req is high, in which case the other requester wins.
REQ-017 If the winner is not decided by ownership, the block SHALL select the single requester when only one req is high and rr_ptr when both are high; with no req high, nothing SHALL be granted.
REQ-018 At most one gnt_i SHALL be high per cycle; gnt_i SHALL never be high while req_i is low.
REQ-019 In a cycle with a winner, WE, funct3, A and WD SHALL equal the winner's we, funct3, addr and wdata.
REQ-020 In a cycle with no winner, the cache port SHALL be driven to WE=0, funct3=3'b010, A=0 and WD=0.
REQ-021 A store SHALL complete at the rising edge closing its grant cycle; the block SHALL produce no response for a store.
REQ-022 For a granted load, rdata_i SHALL capture RD at the closing edge, and rvalid_i SHALL be high for exactly the next cycle.
REQ-023 rdata_i SHALL hold its value until the next load granted to requester i.
REQ-024 Back-to-back loads SHALL sustain one grant per cycle, with rvalid_i high on consecutive cycles.
REQ-025 After a grant to requester i, owner SHALL become Ri if lock_i is high and NONE otherwise, and rr_ptr SHALL become the other requester.
REQ-026 After a grant, hold_cnt SHALL become min(hold_cnt+1, MAX_HOLD) if the same requester won the previous cycle, and 1 otherwise.
REQ-027 In a cycle with no grant, owner SHALL become NONE and hold_cnt SHALL become 0.
REQ-028 If the owner deasserts req, ownership SHALL be released in that same cycle and the other requester SHALL be eligible in that cycle.
REQ-029 A forced switch caused by hold_cnt saturation SHALL clear the previous owner's lock ownership.
REQ-030 Requester inputs SHALL be sampled only in grant cycles; a requester SHALL hold its req and payload stable until it sees gnt.

Reset
REQ-031 While rst is high, the block SHALL set owner=NONE, rr_ptr=0, hold_cnt=0, rvalid_0=rvalid_1=0 and rdata_0=rdata_1=0.
REQ-032 While rst is high, no gnt_i SHALL be asserted and the cache port SHALL be driven to the idle values of REQ-020.
REQ-033 A load granted in the cycle before rst asserts SHALL produce no rvalid pulse.
REQ-034 On the first edge after rst deasserts, arbitration SHALL resume using the reset state.

Verification
REQ-035 The bench SHALL check: after reset, req_0=req_1=1, both loads, lock low -> gnt_0 in cycle 1, gnt_1 in cycle 2, gnt_0 in cycle 3, alternating.
REQ-036 The bench SHALL check: req_0 SW of 0xDEADBEEF to 0x10000, then req_0 load with funct3=3'b010 from 0x10000 -> rdata_0=0xDEADBEEF with rvalid_0 high the cycle after the load grant.
REQ-037 The bench SHALL check: lock_0=1, req_0 held high, req_1 raised at cycle 0 with MAX_HOLD=8 -> gnt_0 for 8 consecutive cycles, then gnt_1, and owner no longer R0.
REQ-038 The bench SHALL check: a load with funct3=3'b100 from 0x10001 after an SB of 0x5A to that address -> rdata=0x0000005A.
REQ-039 The bench SHALL check: rst asserted asynchronously in the cycle after a granted load -> rvalid stays 0, and all outputs are 0 except funct3=3'b010.
REQ-040 The bench SHALL check: no req for 3 cycles -> WE=0 and A=0 throughout, and hold_cnt=0 on the next grant.
